shiftreg_seq: RTL

Command sequencer that sits directly upstream of the 4-bit mode-controlled shift register and drives its mode, serial-in and parallel-data inputs cycle by cycle. It accepts multi-cycle commands (hold, load, rotate-right, shift-left) through a valid/ready handshake and buffers them in a small FIFO. It then expands each command into per-clock `m`/`si`/`d` values. Mode encoding on `m`: 00 no change, 01 parallel load, 10 rotate right, 11 shift left with si.

---
 rtl/shiftreg_seq_if.sv | 25 ++
 rtl/shiftreg_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_seq_if.sv
// Command channel into shiftreg_seq: a valid/ready push port for op/cnt/data commands.
// A command transfers on a rising edge where cmd_valid && cmd_ready; the source holds it stable while cmd_ready=0.
interface shiftreg_seq_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_cnt;
    logic [7:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_cnt,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_cnt,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/shiftreg_seq.sv
// Command sequencer: queues hold/load/rotate/shift commands and expands them into per-cycle m/si/d for the shift register.
// Optional macro SHIFTREG_SEQ_ABORT_EN adds an `abort` input that flushes the queue and forces IDLE.
module shiftreg_seq #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SHIFTREG_SEQ_ABORT_EN
    input  logic              abort,
`endif
    shiftreg_seq_if.slave     cmd,
    output logic [1:0]        m,
    output logic              si,
    output logic [3:0]        d,
    output logic              busy,
    output logic              done,
    output logic              dbg_state_o
);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t     state_q, state_d;

    logic [1:0] fifo_op_q   [DEPTH];
    logic [2:0] fifo_cnt_q  [DEPTH];
    logic [7:0] fifo_data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [1:0] op_q, op_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic [2:0] idx_q, idx_d;

    logic [1:0] m_q, m_d;
    logic       si_q, si_d;
    logic [3:0] d_q, d_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic abort_w;
    logic full_w;
    logic empty_w;
    logic push_w;
    logic pop_w;
    logic last_w;

`ifdef SHIFTREG_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign full_w        = (count_q == (AW+1)'(DEPTH));
    assign empty_w       = (count_q == '0);
    assign cmd.cmd_ready = !full_w;
    // A push coinciding with abort is dropped so the flush leaves the queue truly empty.
    assign push_w        = cmd.cmd_valid && !full_w && !abort_w;
    assign last_w        = (idx_q == cnt_q);

    // Command storage carries no reset; occupancy is tracked by count_q/pointers only.
    always_ff @(posedge clk) begin
        if (push_w) begin
            fifo_op_q[wr_ptr_q]   <= cmd.cmd_op;
            fifo_cnt_q[wr_ptr_q]  <= cmd.cmd_cnt;
            fifo_data_q[wr_ptr_q] <= cmd.cmd_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop_w   = 1'b0;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (!empty_w) begin
                    pop_w   = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (last_w) begin
                    if (!empty_w) begin
                        pop_w = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop_w) begin
            op_d   = fifo_op_q[rd_ptr_q];
            cnt_d  = fifo_cnt_q[rd_ptr_q];
            data_d = fifo_data_q[rd_ptr_q];
            idx_d  = 3'd0;
        end
        if (abort_w) begin
            state_d = IDLE;
            pop_w   = 1'b0;
            idx_d   = 3'd0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + (AW+1)'(push_w) - (AW+1)'(pop_w);
        if (push_w) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_w)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (abort_w) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Outputs reflect the cycle being executed now, registered one edge later.
    always_comb begin
        m_d    = 2'b00;
        si_d   = 1'b0;
        d_d    = 4'h0;
        busy_d = 1'b0;
        done_d = 1'b0;
        if (state_q == EXEC && !abort_w) begin
            m_d    = op_q;
            busy_d = 1'b1;
            done_d = last_w;
            case (op_q)
                2'b01:   d_d  = data_q[3:0];
                2'b11:   si_d = data_q[idx_q];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q    <= 2'b00;
            si_q   <= 1'b0;
            d_q    <= 4'h0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            m_q    <= m_d;
            si_q   <= si_d;
            d_q    <= d_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign m           = m_q;
    assign si          = si_q;
    assign d           = d_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule
